// File: rtl/output_writer.sv
// output_writer: gathers per-column PE results into per-lane FIFOs, packs them lane-major into
// SPAD words and writes them to consecutive addresses. Define OUTPUT_WRITER_RELU_EN to clamp negatives to 0.
module output_writer #(
  parameter int DATA_WIDTH      = 8,
  parameter int SPAD_DATA_WIDTH = 64,
  parameter int SPAD_N          = SPAD_DATA_WIDTH / DATA_WIDTH,
  parameter int ADDR_WIDTH      = 8,
  parameter int COLS            = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_en,
  input  logic                       i_reg_clear,
  input  logic [ADDR_WIDTH-1:0]      i_start_addr,
  input  logic [ADDR_WIDTH-1:0]      i_elem_count,
  input  logic [COLS*DATA_WIDTH-1:0] i_data,
  input  logic [COLS-1:0]            i_data_valid,
  output logic [COLS-1:0]            o_fifo_full,
  output logic                       o_overflow,
  output logic                       o_spad_write_en,
  output logic [ADDR_WIDTH-1:0]      o_spad_write_addr,
  output logic [SPAD_DATA_WIDTH-1:0] o_spad_data_out,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LANE_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SLOT_W = (SPAD_N > 1) ? $clog2(SPAD_N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [LANE_W-1:0]          lane_q, lane_d;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [SPAD_DATA_WIDTH-1:0] pack_q, pack_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0]      popped_q, popped_d;
  logic                       wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
  logic [SPAD_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                       ovf_q, ovf_d;

  logic [COLS-1:0]            fifo_empty, fifo_full, pop, drop;
  logic [COLS*DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0]      head, elem;
  logic [SPAD_DATA_WIDTH-1:0] word;
  logic                       last;

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
    logic                  push;

    assign fifo_empty[c] = (wr_ptr_q == rd_ptr_q);
    assign fifo_full[c]  = ((wr_ptr_q - rd_ptr_q) == (PTR_W+1)'(FIFO_DEPTH));
    // A full lane still accepts a push when the same cycle pops it.
    assign push          = i_data_valid[c] && (!fifo_full[c] || pop[c]);
    assign drop[c]       = i_data_valid[c] && fifo_full[c] && !pop[c];
    assign fifo_head[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q[PTR_W-1:0]];

    // NOTE: storage has no reset; the pointers alone define emptiness, so stale entries are never read.
    always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= i_data[c*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge i_clk) begin
      if (!i_nrst || i_reg_clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop[c]) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign head = fifo_head[lane_q*DATA_WIDTH +: DATA_WIDTH];
`ifdef OUTPUT_WRITER_RELU_EN
  assign elem = head[DATA_WIDTH-1] ? '0 : head;
`else
  assign elem = head;
`endif

  assign ovf_d = ovf_q | (|drop);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    lane_d   = lane_q;
    slot_d   = slot_q;
    pack_d   = pack_q;
    addr_d   = addr_q;
    count_d  = count_q;
    popped_d = popped_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    pop      = '0;
    word     = pack_q;
    word[slot_q*DATA_WIDTH +: DATA_WIDTH] = elem;
    last     = (ADDR_WIDTH'(popped_q + 1'b1) == count_q);

    case (state_q)
      S_IDLE: begin
        if (i_en) begin
          addr_d   = i_start_addr;
          count_d  = i_elem_count;
          lane_d   = '0;
          slot_d   = '0;
          pack_d   = '0;
          popped_d = '0;
          state_d  = (i_elem_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // The lane pointer only moves on a pop, which keeps lane-major order through stalls.
        if (!fifo_empty[lane_q]) begin
          pop[lane_q] = 1'b1;
          popped_d    = popped_q + 1'b1;
          lane_d      = (lane_q == LANE_W'(COLS-1)) ? '0 : lane_q + 1'b1;
          if (slot_q == SLOT_W'(SPAD_N-1) || last) begin
            wen_d   = 1'b1;
            waddr_d = addr_q;
            wdata_d = word;
            addr_d  = addr_q + 1'b1;
            pack_d  = '0;
            slot_d  = '0;
          end else begin
            pack_d  = word;
            slot_d  = slot_q + 1'b1;
          end
          if (last) state_d = S_LAST;
        end
      end
      S_LAST:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      state_q  <= S_IDLE;
      lane_q   <= '0;
      slot_q   <= '0;
      pack_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      popped_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      slot_q   <= slot_d;
      pack_q   <= pack_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      popped_q <= popped_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_fifo_full       = fifo_full;
  assign o_overflow        = ovf_q;
  assign o_spad_write_en   = wen_q;
  assign o_spad_write_addr = waddr_q;
  assign o_spad_data_out   = wdata_q;
  assign o_busy            = (state_q == S_RUN) || (state_q == S_LAST);
  assign o_done            = (state_q == S_DONE);
endmodule
